// File: rtl/dmem_responder_pkg.sv
// dmem_responder_pkg: shared bus command, pipe packet and tag/LFSR helpers for the data-memory responder
package dmem_responder_pkg;

   localparam int XLEN       = 32;
   localparam int DMEM_TAG_W = 4;

   typedef enum logic [1:0] {
      BUS_NONE  = 2'h0,
      BUS_LOAD  = 2'h1,
      BUS_STORE = 2'h2
   } BUS_COMMAND;

   typedef struct packed {
      logic                  valid;
      logic [DMEM_TAG_W-1:0] tag;
      logic                  is_load;
      logic [63:0]           data;
   } DMEM_PIPE_PACKET;

   // Tag 0 means "not accepted", so the pointer cycles 1..15
   function automatic logic [DMEM_TAG_W-1:0] dmem_next_tag(input logic [DMEM_TAG_W-1:0] t);
      return (t == 4'd15) ? 4'd1 : t + 4'd1;
   endfunction

   // Right-shifting Galois form of x^8+x^6+x^5+x^4+1
   function automatic logic [7:0] dmem_lfsr_step(input logic [7:0] s);
      return s[0] ? ((s >> 1) ^ 8'hB8) : (s >> 1);
   endfunction

endpackage

// File: rtl/dmem_delay_pipe.sv
// dmem_delay_pipe: fixed-latency shift pipe carrying accepted requests to their completion cycle
module dmem_delay_pipe
   import dmem_responder_pkg::*;
#(
   parameter int MEM_LATENCY = 4
) (
   input  logic            clock,
   input  logic            reset,
   input  DMEM_PIPE_PACKET pkt_in,
   output DMEM_PIPE_PACKET pkt_out
);

   DMEM_PIPE_PACKET stage_q [MEM_LATENCY];
   DMEM_PIPE_PACKET stage_d [MEM_LATENCY];

   // Every stage advances each cycle; there is no stall
   always_comb begin
      stage_d[0] = pkt_in;
      for (int i = 1; i < MEM_LATENCY; i++) stage_d[i] = stage_q[i-1];
   end

   // Reset drops everything in flight
   always_ff @(posedge clock or posedge reset) begin
      if (reset) for (int i = 0; i < MEM_LATENCY; i++) stage_q[i] <= '0;
      else stage_q <= stage_d;
   end

   assign pkt_out = stage_q[MEM_LATENCY-1];

endmodule

// File: rtl/dmem_responder.sv
// dmem_responder: in-order fixed-latency data memory endpoint; optional random refusals via DMEM_BACKPRESSURE_EN
module dmem_responder
   import dmem_responder_pkg::*;
#(
   parameter int MEM_LATENCY     = 4,
   parameter int MEM_DEPTH_WORDS = 8192
) (
   input  logic            clock,
   input  logic            reset,
   input  logic [1:0]      proc2mem_command,
   input  logic [XLEN-1:0] proc2mem_addr,
   input  logic [63:0]     proc2mem_data,
   output logic [3:0]      mem2proc_response,
   output logic [63:0]     mem2proc_data,
   output logic [3:0]      mem2proc_tag
);

   localparam int IDX_W = $clog2(MEM_DEPTH_WORDS);

   logic [63:0]      mem_q [MEM_DEPTH_WORDS];
   logic [IDX_W-1:0] word_idx;
   logic [15:0]      outstanding_q, outstanding_d;
   logic [3:0]       next_tag_q, next_tag_d;
   logic             is_load, is_store, accept, stall;
   logic             unused_addr_bits;
   DMEM_PIPE_PACKET  pipe_in, pipe_out;

   assign word_idx         = proc2mem_addr[3 +: IDX_W];
   assign unused_addr_bits = ^{proc2mem_addr[2:0], proc2mem_addr[XLEN-1:IDX_W+3]};
   assign is_load          = (proc2mem_command == BUS_LOAD);
   assign is_store         = (proc2mem_command == BUS_STORE);

`ifdef DMEM_BACKPRESSURE_EN
   logic [7:0] lfsr_q, lfsr_d;

   // Free-running LFSR decides which cycles refuse requests
   always_comb lfsr_d = dmem_lfsr_step(lfsr_q);

   // LFSR register restarts from the seed on reset
   always_ff @(posedge clock or posedge reset) begin
      if (reset) lfsr_q <= 8'h5A;
      else lfsr_q <= lfsr_d;
   end

   assign stall = (lfsr_q[1:0] == 2'b00);
`else
   assign stall = 1'b0;
`endif

   // Accept decision, tag pool update and the packet entering the pipe
   always_comb begin
      accept            = !reset && (is_load || is_store) && !outstanding_q[next_tag_q] && !stall;
      mem2proc_response = accept ? next_tag_q : 4'd0;
      next_tag_d        = accept ? dmem_next_tag(next_tag_q) : next_tag_q;
      outstanding_d     = outstanding_q;
      if (pipe_out.valid) outstanding_d[pipe_out.tag] = 1'b0;
      if (accept) outstanding_d[next_tag_q] = 1'b1;
      pipe_in.valid     = accept;
      pipe_in.tag       = next_tag_q;
      pipe_in.is_load   = is_load;
      pipe_in.data      = is_load ? mem_q[word_idx] : 64'd0;
   end

   // Tag pool state; a completing tag frees up for the following cycle
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         outstanding_q <= '0;
         next_tag_q    <= 4'd1;
      end else begin
         outstanding_q <= outstanding_d;
         next_tag_q    <= next_tag_d;
      end
   end

   // Backing store survives reset; stores land at the end of the accept cycle
   always_ff @(posedge clock) begin
      if (accept && is_store) mem_q[word_idx] <= proc2mem_data;
   end

   dmem_delay_pipe #(.MEM_LATENCY(MEM_LATENCY)) u_pipe (
      .clock  (clock),
      .reset  (reset),
      .pkt_in (pipe_in),
      .pkt_out(pipe_out)
   );

   assign mem2proc_tag  = pipe_out.valid ? pipe_out.tag : 4'd0;
   assign mem2proc_data = (pipe_out.valid && pipe_out.is_load) ? pipe_out.data : 64'd0;

endmodule

// File: tb/tb_dmem_responder.sv
// tb_dmem_responder: two responders (latency 4 and 1) checked against a time-slot reference model
module tb_dmem_responder;
   import dmem_responder_pkg::*;

   localparam int DEPTH = 64;
`ifdef DMEM_BACKPRESSURE_EN
   localparam bit BP = 1'b1;
`else
   localparam bit BP = 1'b0;
`endif

   logic        clock = 1'b0;
   logic        reset = 1'b1;
   logic [1:0]  cmd   [2];
   logic [31:0] addr  [2];
   logic [63:0] wdata [2];
   logic [3:0]  resp  [2];
   logic [3:0]  tag   [2];
   logic [63:0] rdata [2];

   int          cyc, passed, total;
   int          nt    [2];
   bit          busy  [2][16];
   logic [7:0]  lf    [2];
   logic [63:0] mm    [2][DEPTH];
   int          s_tag [2][16];
   logic [63:0] s_dat [2][16];
   bit          acc   [2];
   int          wi    [2];

   always #5 clock = ~clock;

   dmem_responder #(.MEM_LATENCY(4), .MEM_DEPTH_WORDS(DEPTH)) dut4 (
      .clock(clock), .reset(reset), .proc2mem_command(cmd[0]), .proc2mem_addr(addr[0]),
      .proc2mem_data(wdata[0]), .mem2proc_response(resp[0]), .mem2proc_data(rdata[0]), .mem2proc_tag(tag[0])
   );

   dmem_responder #(.MEM_LATENCY(1), .MEM_DEPTH_WORDS(DEPTH)) dut1 (
      .clock(clock), .reset(reset), .proc2mem_command(cmd[1]), .proc2mem_addr(addr[1]),
      .proc2mem_data(wdata[1]), .mem2proc_response(resp[1]), .mem2proc_data(rdata[1]), .mem2proc_tag(tag[1])
   );

   function automatic int lat(input int i);
      return (i == 0) ? 4 : 1;
   endfunction

   task automatic chk(input string nm, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) passed++;
      else $error("FAIL %s cycle=%0d observed=%h expected=%h", nm, cyc, obs, exp);
   endtask

   task automatic model_reset();
      for (int i = 0; i < 2; i++) begin
         nt[i] = 1;
         lf[i] = 8'h5A;
         for (int k = 0; k < 16; k++) begin
            busy[i][k]  = 1'b0;
            s_tag[i][k] = 0;
            s_dat[i][k] = 64'd0;
         end
      end
   endtask

   task automatic drive(input int i, input logic [1:0] c, input logic [31:0] a, input logic [63:0] d);
      cmd[i]   = c;
      addr[i]  = a;
      wdata[i] = d;
   endtask

   task automatic idle(input int n);
      for (int k = 0; k < n; k++) begin
         drive(0, BUS_NONE, $urandom, $urandom);
         drive(1, BUS_NONE, $urandom, $urandom);
         step();
      end
   endtask

   // One cycle: check the DUT mid-cycle, then advance the model by the spec's rules
   task automatic step();
      @(negedge clock);
      for (int i = 0; i < 2; i++) begin
         int slot = cyc % 16;
         int due  = (cyc + lat(i)) % 16;
         int w    = int'((addr[i] >> 3) % DEPTH);
         bit st   = BP && (lf[i] % 4 == 0);
         acc[i] = (cmd[i] == 2'd1 || cmd[i] == 2'd2) && !busy[i][nt[i]] && !st;
         chk($sformatf("resp%0d", i), resp[i], acc[i] ? nt[i] : 0);
         chk($sformatf("tag%0d", i), tag[i], s_tag[i][slot]);
         chk($sformatf("data%0d", i), rdata[i], s_dat[i][slot]);
         if (s_tag[i][slot] != 0) busy[i][s_tag[i][slot]] = 1'b0;
         s_tag[i][slot] = 0;
         s_dat[i][slot] = 64'd0;
         if (acc[i]) begin
            busy[i][nt[i]] = 1'b1;
            s_tag[i][due]  = nt[i];
            s_dat[i][due]  = (cmd[i] == 2'd1) ? mm[i][w] : 64'd0;
            if (cmd[i] == 2'd2) mm[i][w] = wdata[i];
            nt[i] = (nt[i] == 15) ? 1 : nt[i] + 1;
         end
         lf[i] = lf[i][0] ? ((lf[i] >> 1) ^ 8'hB8) : (lf[i] >> 1);
      end
      cyc++;
      @(posedge clock);
      #1;
   endtask

   // Reset with LOAD presented: nothing may be accepted or completed
   task automatic do_reset();
      reset = 1'b1;
      drive(0, BUS_LOAD, $urandom, 0);
      drive(1, BUS_LOAD, $urandom, 0);
      @(negedge clock);
      for (int i = 0; i < 2; i++) begin
         chk($sformatf("rst_resp%0d", i), resp[i], 0);
         chk($sformatf("rst_tag%0d", i), tag[i], 0);
         chk($sformatf("rst_data%0d", i), rdata[i], 0);
      end
      model_reset();
      cyc++;
      @(posedge clock);
      #1;
      reset = 1'b0;
      drive(0, BUS_NONE, 0, 0);
      drive(1, BUS_NONE, 0, 0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog expired at cycle %0d", cyc);
      $fatal(1, "watchdog");
   end

   initial begin
      cyc = 0;
      passed = 0;
      total = 0;
      model_reset();
      drive(0, BUS_NONE, 0, 0);
      drive(1, BUS_NONE, 0, 0);
      @(posedge clock);
      #1;
      do_reset();
      // Preload every word of both memories, retrying refused stores; high/low address bits are noise
      wi[0] = 0;
      wi[1] = 0;
      while (wi[0] < DEPTH || wi[1] < DEPTH) begin
         for (int i = 0; i < 2; i++)
            drive(i, (wi[i] < DEPTH) ? BUS_STORE : BUS_NONE,
                  ($urandom & ~32'h1F8) | (32'(wi[i] % DEPTH) << 3), {$urandom, $urandom});
         step();
         for (int i = 0; i < 2; i++) if (acc[i]) wi[i]++;
      end
      idle(6);
      // Store then load of the same word in the next cycle
      do_reset();
      drive(0, BUS_STORE, 32'h100, 64'hDEAD_BEEF_0123_4567);
      drive(1, BUS_STORE, 32'h208, 64'h0BAD_F00D_CAFE_1234);
      step();
      drive(0, BUS_LOAD, 32'h104, 0);
      drive(1, BUS_LOAD, 32'h20C, 0);
      step();
      idle(6);
      // Back-to-back loads to exercise tag wrap 15 -> 1
      for (int k = 0; k < 20; k++) begin
         drive(0, BUS_LOAD, $urandom, 0);
         drive(1, BUS_LOAD, $urandom, 0);
         step();
      end
      idle(5);
      // Ignored commands
      for (int k = 0; k < 8; k++) begin
         drive(0, (k % 2 != 0) ? 2'd3 : BUS_NONE, $urandom, $urandom);
         drive(1, (k % 2 != 0) ? BUS_NONE : 2'd3, $urandom, $urandom);
         step();
      end
      // Random mixed traffic
      for (int k = 0; k < 300; k++) begin
         drive(0, 2'($urandom_range(0, 3)), $urandom, {$urandom, $urandom});
         drive(1, 2'($urandom_range(0, 3)), $urandom, {$urandom, $urandom});
         step();
      end
      // Reset with loads in flight
      for (int k = 0; k < 3; k++) begin
         drive(0, BUS_LOAD, $urandom, 0);
         drive(1, BUS_LOAD, $urandom, 0);
         step();
      end
      do_reset();
      idle(5);
      drive(0, BUS_LOAD, $urandom, 0);
      drive(1, BUS_LOAD, $urandom, 0);
      step();
      idle(5);
      // LOAD held for 64 cycles
      for (int k = 0; k < 64; k++) begin
         drive(0, BUS_LOAD, $urandom, 0);
         drive(1, BUS_LOAD, $urandom, 0);
         step();
      end
      idle(6);
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
